// File: rtl/exp_adjust_pipe.sv
// Exponent adjust unit: biased exponent +/- shift amount, saturating,
// two-stage valid/ready pipeline with sticky overflow/underflow flags.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake; exp_a, shamt, op carried with it
//   out_valid/out_ready output handshake; exp_y, ovf, unf carried with it
//   clr_sticky        clears sticky_ovf / sticky_unf (a same-cycle set wins)
//   sticky_ovf/unf    accumulated per-result flags of accepted outputs
module exp_adjust_pipe #(
   parameter int EW = 8,
   parameter int SW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [EW-1:0] exp_a,
   input  logic [SW-1:0] shamt,
   input  logic          op,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [EW-1:0] exp_y,
   output logic          ovf,
   output logic          unf,
   input  logic          clr_sticky,
   output logic          sticky_ovf,
   output logic          sticky_unf
);

   localparam logic [EW:0] MAXR = {1'b0, {EW{1'b1}}};

   typedef struct packed {
      logic [EW:0] r;
      logic        op;
   } s1_t;

   logic          s1_valid;
   s1_t           s1;
   logic          s2_adv;
   logic          acc;
   logic [EW:0]   shx;
   logic [EW:0]   r_nxt;
   logic [EW-1:0] y_nxt;
   logic          ovf_nxt;
   logic          unf_nxt;

   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;
   assign acc      = out_valid && out_ready;

   // One extra result bit: carry for add, borrow for subtract.
   always_comb begin
      shx   = {{(EW+1-SW){1'b0}}, shamt};
      r_nxt = op ? ({1'b0, exp_a} - shx)
                 : ({1'b0, exp_a} + shx);
   end

   // All-ones is the reserved code, so reaching it already counts as
   // overflow; a zero result counts as underflow.
   always_comb begin
      y_nxt   = s1.r[EW-1:0];
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
      if (!s1.op) begin
         if (s1.r >= MAXR) begin
            y_nxt   = {EW{1'b1}};
            ovf_nxt = 1'b1;
         end
      end else if (s1.r[EW] || s1.r == '0) begin
         y_nxt   = '0;
         unf_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1.r  <= r_nxt;
            s1.op <= op;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         exp_y     <= '0;
         ovf       <= 1'b0;
         unf       <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            exp_y <= y_nxt;
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_ovf <= 1'b0;
         sticky_unf <= 1'b0;
      end else begin
         sticky_ovf <= (sticky_ovf && !clr_sticky) || (acc && ovf);
         sticky_unf <= (sticky_unf && !clr_sticky) || (acc && unf);
      end
   end

endmodule

// File: tb/tb_exp_adjust_pipe.sv
// Directed bench for exp_adjust_pipe (EW=8, SW=5) with a result
// scoreboard, handshake model and stall-stability monitor.
module tb_exp_adjust_pipe;

   typedef struct packed {
      logic [7:0] y;
      logic       o;
      logic       u;
   } res_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] exp_a;
   logic [4:0] shamt;
   logic       op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] exp_y;
   logic       ovf;
   logic       unf;
   logic       clr_sticky;
   logic       sticky_ovf;
   logic       sticky_unf;

   int   total = 0;
   int   bad   = 0;
   res_t q[$];
   bit   hold_v = 0;
   res_t held;

   exp_adjust_pipe #(.EW(8), .SW(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .exp_a      (exp_a),
      .shamt      (shamt),
      .op         (op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .exp_y      (exp_y),
      .ovf        (ovf),
      .unf        (unf),
      .clr_sticky (clr_sticky),
      .sticky_ovf (sticky_ovf),
      .sticky_unf (sticky_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic res_t model(logic [7:0] a, logic [4:0] s,
                                  logic o);
      int   r;
      res_t m;
      m = '0;
      if (!o) begin
         r = int'(a) + int'(s);
         if (r >= 255) begin
            m.y = 8'hff;
            m.o = 1'b1;
         end else begin
            m.y = 8'(r);
         end
      end else begin
         r = int'(a) - int'(s);
         if (r <= 0) m.u = 1'b1;
         else        m.y = 8'(r);
      end
      return m;
   endfunction

   task automatic chk1(string tag, logic got, logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
      end
   endtask

   task automatic chk8(string tag, logic [7:0] got, logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic chk10(string tag, logic [9:0] got, logic [9:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got y=%0d o=%0b u=%0b exp y=%0d o=%0b u=%0b",
                tag, got[9:2], got[1], got[0],
                exp[9:2], exp[1], exp[0]);
      end
   endtask

   // Queue size at a falling edge equals beats currently in the pipe;
   // only a full, stalled pipe may refuse input.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         hold_v = 0;
      end else begin
         chk1("in_ready", in_ready, !(q.size() == 2 && !out_ready));
         if (hold_v) begin
            chk1("hold_valid", out_valid, 1'b1);
            chk10("hold_data", {exp_y, ovf, unf}, held);
         end
         hold_v = out_valid && !out_ready;
         held   = {exp_y, ovf, unf};
         if (out_valid && out_ready) begin
            chk1("sb_nonempty", q.size() > 0, 1'b1);
            if (q.size() > 0) chk10("result", {exp_y, ovf, unf},
                                    q.pop_front());
         end
         if (in_valid && in_ready)
            q.push_back(model(exp_a, shamt, op));
      end
   end

   task automatic send(logic [7:0] a, logic [4:0] s, logic o);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1;
      exp_a    = a;
      shamt    = s;
      op       = o;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      chk1("send_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 50);
      chk1("wait_out", out_valid, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((q.size() != 0 || out_valid) && n < 100);
      chk1("drained", q.size() == 0 && !out_valid, 1'b1);
   endtask

   task automatic clr_pulse();
      @(posedge clk); #1;
      clr_sticky = 1'b1;
      @(posedge clk); #1;
      clr_sticky = 1'b0;
   endtask

   initial begin
      int idx;
      int cyc;
      rst        = 1'b1;
      in_valid   = 1'b0;
      exp_a      = '0;
      shamt      = '0;
      op         = 1'b0;
      out_ready  = 1'b1;
      clr_sticky = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk10("rst_out", {exp_y, ovf, unf}, 10'd0);
      chk1("rst_sticky_ovf", sticky_ovf, 1'b0);
      chk1("rst_sticky_unf", sticky_unf, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk1("rst_in_ready", in_ready, 1'b1);

      // 1: latency of exactly two cycles
      @(posedge clk); #1;
      in_valid = 1'b1;
      exp_a    = 8'd100;
      shamt    = 5'd5;
      op       = 1'b0;
      @(negedge clk);
      chk1("t1_accept", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk1("t1_lat1", out_valid, 1'b0);
      @(negedge clk);
      chk1("t1_lat2", out_valid, 1'b1);
      chk10("t1_y", {exp_y, ovf, unf}, {8'd105, 1'b0, 1'b0});

      // 2: overflow saturation and sticky clear
      send(8'd250, 5'd10, 1'b0);
      wait_out();
      chk10("t2_y", {exp_y, ovf, unf}, {8'd255, 1'b1, 1'b0});
      @(negedge clk);
      chk1("t2_sticky_set", sticky_ovf, 1'b1);
      clr_pulse();
      @(negedge clk);
      chk1("t2_sticky_clr", sticky_ovf, 1'b0);

      // 3: underflow cases
      send(8'd3, 5'd5, 1'b1);
      send(8'd5, 5'd5, 1'b1);
      send(8'd6, 5'd5, 1'b1);
      drain();
      chk1("t3_sticky_unf", sticky_unf, 1'b1);
      chk1("t3_sticky_ovf", sticky_ovf, 1'b0);

      // 5: reset with two beats in flight
      out_ready = 1'b0;
      send(8'd10, 5'd0, 1'b0);
      send(8'd20, 5'd0, 1'b0);
      @(negedge clk);
      chk1("t5_full", in_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk1("t5_out_valid", out_valid, 1'b0);
      chk1("t5_sticky_unf", sticky_unf, 1'b0);
      chk1("t5_sticky_ovf", sticky_ovf, 1'b0);
      send(8'd7, 5'd0, 1'b0);
      wait_out();
      chk8("t5_y", exp_y, 8'd7);
      drain();

      // 4: back-to-back with random backpressure
      idx = 1;
      cyc = 0;
      while ((idx <= 8 || q.size() != 0 || out_valid) && cyc < 300) begin
         @(posedge clk); #1;
         out_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
         if (idx <= 8) begin
            in_valid = 1'b1;
            exp_a    = 8'(idx);
            shamt    = 5'd1;
            op       = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         cyc++;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      chk8("t4_count", 8'(idx), 8'd9);

      // 6: clear and flagged acceptance in the same cycle
      chk1("t6_pre", sticky_unf, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b1;
      exp_a    = 8'd2;
      shamt    = 5'd9;
      op       = 1'b1;
      @(negedge clk);
      chk1("t6_accept", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      clr_sticky = 1'b1;
      @(negedge clk);
      chk1("t6_out_valid", out_valid, 1'b1);
      chk1("t6_unf", unf, 1'b1);
      @(posedge clk); #1;
      clr_sticky = 1'b0;
      @(negedge clk);
      chk1("t6_sticky_unf", sticky_unf, 1'b1);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
